// File: rtl/mem_access_initiator_if.sv
// Main memory bus between the instruction/operand initiator and the memory controller.
`ifndef INSTRUCTION_FETCH
`define INSTRUCTION_FETCH 1'b0
`endif
`ifndef DATA_READ
`define DATA_READ 1'b1
`endif

// Handshake: the master raises exactly one enable with address/read_type/write_data
// stable and holds them until it samples mem_finished=1 (read_data valid that cycle);
// on that edge the enable drops and it stays low for at least one cycle.
interface mem_access_initiator_if;
   logic [11:0] address;
   logic        read_enable;
   logic        write_enable;
   logic [11:0] write_data;
   logic        read_type;
   logic [11:0] read_data;
   logic        mem_finished;

   modport master (
      output address, read_enable, write_enable, write_data, read_type,
      input  read_data, mem_finished
   );

   modport slave (
      input  address, read_enable, write_enable, write_data, read_type,
      output read_data, mem_finished
   );
endinterface

// File: rtl/mem_access_initiator.sv
// PDP-8 style instruction fetch, effective-address resolution (page, indirect,
// auto-index) and operand fetch, issued as single-enable accesses on the memory bus.
module mem_access_initiator #(
   parameter logic [11:0] AUTO_LO      = 12'o0010,
   parameter logic [11:0] AUTO_HI      = 12'o0017,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] pc,
   output logic        busy,
   output logic        done,
   output logic [11:0] ir,
   output logic [11:0] ea,
   output logic [11:0] operand,
   output logic [3:0]  dbg_state,
   mem_access_initiator_if.master bus
);

   typedef enum logic [3:0] {
      S_DRAIN      = 4'd0,
      S_IDLE       = 4'd1,
      S_FETCH      = 4'd2,
      S_DECODE     = 4'd3,
      S_IND_READ   = 4'd4,
      S_AUTO_WRITE = 4'd5,
      S_OPER_READ  = 4'd6,
      S_DONE       = 4'd7
   } state_t;

   state_t      state;
   logic [4:0]  page_q;
   logic [11:0] ptr;
   logic [7:0]  drain_cnt;
   logic [2:0]  op;
   logic [11:0] base;
   logic        enabled;
   logic        finished;
   logic        needs_oper;
   logic        is_auto;

   assign op         = ir[11:9];
   // Page base comes from the latched pc, never from an indirect pointer.
   assign base       = ir[7] ? {page_q, ir[6:0]} : {5'b0, ir[6:0]};
   assign enabled    = bus.read_enable | bus.write_enable;
   assign finished   = enabled & bus.mem_finished;
   assign needs_oper = (op <= 3'd2);
   assign is_auto    = (ea >= AUTO_LO) && (ea <= AUTO_HI);
   assign dbg_state  = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_DRAIN;
         drain_cnt        <= 8'(DRAIN_CYCLES);
         busy             <= 1'b1;
         done             <= 1'b0;
         ir               <= '0;
         ea               <= '0;
         operand          <= '0;
         page_q           <= '0;
         ptr              <= '0;
         bus.address      <= '0;
         bus.read_enable  <= 1'b0;
         bus.write_enable <= 1'b0;
         bus.write_data   <= '0;
         bus.read_type    <= 1'b0;
      end else begin
         case (state)
            S_DRAIN: begin
               if (drain_cnt <= 8'd1) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - 8'd1;
               end
            end
            S_IDLE: begin
               if (start) begin
                  page_q          <= pc[11:7];
                  ea              <= '0;
                  operand         <= '0;
                  busy            <= 1'b1;
                  bus.address     <= pc;
                  bus.read_type   <= `INSTRUCTION_FETCH;
                  bus.read_enable <= 1'b1;
                  state           <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (finished) begin
                  ir              <= bus.read_data;
                  bus.read_enable <= 1'b0;
                  state           <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (op >= 3'd6) begin
                  ea    <= '0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  ea <= base;
                  if (ir[8] || needs_oper) begin
                     bus.address     <= base;
                     bus.read_type   <= `DATA_READ;
                     bus.read_enable <= 1'b1;
                     state           <= ir[8] ? S_IND_READ : S_OPER_READ;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_IND_READ: begin
               if (finished) begin
                  bus.read_enable <= 1'b0;
                  if (is_auto) begin
                     ptr   <= bus.read_data + 12'd1;
                     state <= S_AUTO_WRITE;
                  end else begin
                     ea <= bus.read_data;
                     if (needs_oper) begin
                        state <= S_OPER_READ;
                     end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                     end
                  end
               end
            end
            // Entered with enables low after a previous access: issue on the next edge.
            S_AUTO_WRITE: begin
               if (!enabled) begin
                  bus.address      <= ea;
                  bus.write_data   <= ptr;
                  bus.write_enable <= 1'b1;
               end else if (finished) begin
                  bus.write_enable <= 1'b0;
                  ea               <= ptr;
                  if (needs_oper) begin
                     state <= S_OPER_READ;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_OPER_READ: begin
               if (!enabled) begin
                  bus.address     <= ea;
                  bus.read_type   <= `DATA_READ;
                  bus.read_enable <= 1'b1;
               end else if (finished) begin
                  operand         <= bus.read_data;
                  bus.read_enable <= 1'b0;
                  done            <= 1'b1;
                  state           <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state     <= S_DRAIN;
               drain_cnt <= 8'(DRAIN_CYCLES);
               busy      <= 1'b1;
            end
         endcase
      end
   end

endmodule
